response_tx: RTL and testbench

Transmit-side counterpart of the command decoder. It accepts one result (opcode echo plus 8-bit data) from the execution logic through a valid/ack handshake. It builds a 3-byte response frame (header, data, checksum) and serialises it on the UART TX line as 8N1, LSB first. It sits between the command execution unit and the FPGA TX pin.

---
 rtl/response_tx.sv | 165 ++++++++++++++++
 tb/tb_response_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/response_tx.sv
// Response frame transmitter: latches one result, then sends header, data and
// checksum bytes back to back on a UART TX line (8N1, LSB first).
module response_tx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       res_valid,
    input  logic [1:0] res_opcode,
    input  logic [7:0] res_data,
    output logic       res_ack,
    output logic       tx,
    output logic       tx_busy
);

    localparam int unsigned      BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [1:0]       LAST_BYTE = 2'd2;
    localparam logic [2:0]       LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          byte_q, byte_d;
    logic [7:0]          b0_q, b0_d;
    logic [7:0]          b1_q, b1_d;
    logic [7:0]          b2_q, b2_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                ack_q, ack_d;

    logic [7:0]          cur_byte_c;
    logic [7:0]          header_c;
    logic                baud_wrap_c;

    assign header_c    = {4'hA, 2'b00, res_opcode};
    assign baud_wrap_c = (baud_q == BAUD_LAST);

    // Byte currently on the wire
    always_comb begin
        case (byte_q)
            2'd0:    cur_byte_c = b0_q;
            2'd1:    cur_byte_c = b1_q;
            default: cur_byte_c = b2_q;
        endcase
    end

    // tx is computed one cycle ahead so the pin comes straight from a flop
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        b2_d    = b2_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = '0;
                bit_d  = '0;
                byte_d = '0;
                if (res_valid) begin
                    b0_d    = header_c;
                    b1_d    = res_data;
                    b2_d    = header_c ^ res_data;
                    ack_d   = 1'b1;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_wrap_c) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = cur_byte_c[0];
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_wrap_c) begin
                    baud_d = '0;
                    if (bit_q == LAST_BIT) begin
                        bit_d   = '0;
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = cur_byte_c[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_wrap_c) begin
                    baud_d = '0;
                    if (byte_q == LAST_BYTE) begin
                        byte_d  = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else begin
                        byte_d  = byte_q + 2'd1;
                        tx_d    = 1'b0;
                        state_d = START;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            b2_q    <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            b2_q    <= b2_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign res_ack = ack_q;

endmodule

// File: tb/tb_response_tx.sv
// Scoreboard bench for response_tx: expected frame bytes are queued at issue
// time and a UART decoder pops and compares every byte seen on tx.
module tb_response_tx;

    localparam int unsigned CPB       = 4;
    localparam int unsigned FRAME_CYC = 30 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       res_valid = 1'b0;
    logic [1:0] res_opcode = 2'b00;
    logic [7:0] res_data = 8'h00;
    logic       res_ack;
    logic       tx;
    logic       tx_busy;

    always #5 clk = ~clk;

    response_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .res_valid  (res_valid),
        .res_opcode (res_opcode),
        .res_data   (res_data),
        .res_ack    (res_ack),
        .tx         (tx),
        .tx_busy    (tx_busy)
    );

    int         errors = 0;
    int         checks = 0;
    int         ack_cnt = 0;
    int         acks_exp = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference frame: header = 0xA0 | opcode, then data, then header xor data
    function automatic void push_frame(input logic [1:0] op, input logic [7:0] d);
        logic [7:0] hdr;
        hdr = 8'hA0 + {6'b0, op};
        exp_q.push_back(hdr);
        exp_q.push_back(d);
        exp_q.push_back(hdr ^ d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a result, queue its frame, wait for the ack; idle = non-busy cycles seen first
    task automatic issue(input logic [1:0] op, input logic [7:0] d, output int idle);
        bit ok;
        ok         = 1'b0;
        idle       = 0;
        res_valid  = 1'b1;
        res_opcode = op;
        res_data   = d;
        push_frame(op, d);
        acks_exp++;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (res_ack) begin
                ok = 1'b1;
                break;
            end
            if (!tx_busy) idle++;
        end
        check("ack_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 32'(ok), 32'd1);
        tick();
    endtask

    // UART decoder / scoreboard consumer
    logic [9:0] mon_bits;
    bit         mon_abort;
    bit         mon_glitch;
    logic [7:0] mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && !tx) begin
                mon_bits   = '0;
                mon_abort  = 1'b0;
                mon_glitch = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < int'(CPB); c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (!reset) begin
                            mon_abort = 1'b1;
                            break;
                        end
                        if (c == 0) mon_bits[b] = tx;
                        else if (tx !== mon_bits[b]) mon_glitch = 1'b1;
                    end
                    if (mon_abort) break;
                end
                if (!mon_abort) begin
                    check("framing", 32'({mon_glitch, mon_bits[9], mon_bits[0]}), 32'b010);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", mon_bits[8:1]);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        check("byte", 32'(mon_bits[8:1]), 32'(mon_exp));
                    end
                end
            end
        end
    end

    // Ack pulse properties: single cycle, only out of idle, start bit already on tx
    bit prev_ack = 1'b0;
    bit prev_busy = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (res_ack === 1'b1) begin
                ack_cnt++;
                check("ack_after_idle", 32'({prev_ack, prev_busy}), 32'b00);
                check("ack_start_bit", 32'({tx, tx_busy}), 32'b01);
            end
            prev_ack  = res_ack;
            prev_busy = tx_busy;
        end
    end

    // Busy run length of every completed frame
    int busy_run = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) busy_run = 0;
            else if (tx_busy) busy_run++;
            else begin
                if (busy_run != 0) check("busy_len", 32'(busy_run), 32'(FRAME_CYC));
                busy_run = 0;
            end
        end
    end

    initial begin
        int  idle;
        bit  quiet;

        // Reset and quiet idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({tx, tx_busy, res_ack}), 32'b100);
        reset = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({tx, tx_busy, res_ack} !== 3'b100) quiet = 1'b0;
        end
        check("idle_100_cycles", 32'(quiet), 32'd1);
        tick();

        // Single frame, one-cycle acceptance latency
        issue(2'b10, 8'h5C, idle);
        check("single_latency", 32'(idle), 32'd1);
        tick();
        res_valid = 1'b0;
        wait_idle();

        // Inputs changed mid-frame must not disturb the frame
        issue(2'b10, 8'h5C, idle);
        tick();
        res_valid = 1'b0;
        repeat (48) tick();
        res_data   = 8'hFF;
        res_opcode = 2'b01;
        wait_idle();

        // Back-to-back with valid held: exactly one idle cycle between frames
        issue(2'b01, 8'h00, idle);
        tick();
        res_opcode = 2'b11;
        res_data   = 8'hAA;
        issue(2'b11, 8'hAA, idle);
        check("b2b_idle_gap", 32'(idle), 32'd1);
        tick();
        res_valid = 1'b0;
        wait_idle();

        // Pattern with both end bits set
        issue(2'b11, 8'h81, idle);
        tick();
        res_valid = 1'b0;
        wait_idle();

        // Randomised frames with random mid-frame input noise and gaps
        for (int n = 0; n < 10; n++) begin
            issue(2'($urandom), 8'($urandom), idle);
            tick();
            res_valid = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 100)) tick();
                res_opcode = 2'($urandom);
                res_data   = 8'($urandom);
            end
            wait_idle();
            repeat ($urandom_range(0, 4)) tick();
        end

        // Reset during B1 data bit 3 aborts the frame at once
        issue(2'b10, 8'h5C, idle);
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        repeat (56) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_outputs", 32'({tx, tx_busy, res_ack}), 32'b100);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        res_valid  = 1'b1;
        res_opcode = 2'b00;
        res_data   = 8'h3C;
        reset      = 1'b1;
        issue(2'b00, 8'h3C, idle);
        check("post_reset_latency", 32'(idle), 32'd1);
        tick();
        res_valid = 1'b0;
        wait_idle();

        repeat (20) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("ack_count", 32'(ack_cnt), 32'(acks_exp));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
